// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen encodings and PS/2 key constants
package vga_pkg;

   typedef enum logic [1:0] {
      START    = 2'd0,
      GAME     = 2'd1,
      PLAYER_1 = 2'd2,
      PLAYER_2 = 2'd3
   } screen_e;

   localparam logic [7:0] KEY_START  = 8'h5A;
   localparam logic [7:0] KEY_ABORT  = 8'h76;
   localparam logic [7:0] BREAK_CODE = 8'hF0;

endpackage

// File: rtl/screen_controller_if.sv
// rtl/screen_controller_if.sv - keyboard, score and screen-select signals of the sequencer
interface screen_controller_if;
   import vga_pkg::*;

   logic        vblnk;
   logic [15:0] keycode;
   logic [4:0]  p1_score;
   logic [4:0]  p2_score;
   screen_e     screen;
   logic        game_rst;
   logic        pending;

   modport master (
      output vblnk, keycode, p1_score, p2_score,
      input  screen, game_rst, pending
   );

   modport slave (
      input  vblnk, keycode, p1_score, p2_score,
      output screen, game_rst, pending
   );

endinterface

// File: rtl/key_event_detect.sv
// rtl/key_event_detect.sv - one-cycle strobe on a fresh make code matching code_i
module key_event_detect
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] keycode_i,
   input  logic [7:0]  code_i,
   output logic        strobe_o
);

   logic [15:0] keycode_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         keycode_q <= 16'h0000;
      end else begin
         keycode_q <= keycode_i;
      end
   end

   // A held key repeats the same word, so only a change of word counts as a press.
   assign strobe_o = (keycode_i != keycode_q) &&
                     (keycode_i[15:8] != BREAK_CODE) &&
                     (keycode_i[7:0] == code_i);

endmodule

// File: rtl/screen_controller.sv
// rtl/screen_controller.sv - game flow sequencer committing screen changes on vblnk rising edges
module screen_controller
   import vga_pkg::*;
#(
   parameter logic [4:0] WIN_SCORE  = 5'd10,
   parameter int         WIN_FRAMES = 300
)(
   input  logic                 clk,
   input  logic                 rst,
   screen_controller_if.slave   sc
);

   localparam int                CNT_W    = $clog2(WIN_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_FRAMES - 1);

   logic             vblnk_q;
   logic             fe;
   logic             start_ev;
   logic             abort_ev;
   logic             commit;
   screen_e          target_q, target_d;
   screen_e          screen_q, screen_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic             game_rst_q, game_rst_d;

   key_event_detect u_start_key (
      .clk       (clk),
      .rst       (rst),
      .keycode_i (sc.keycode),
      .code_i    (KEY_START),
      .strobe_o  (start_ev)
   );

   key_event_detect u_abort_key (
      .clk       (clk),
      .rst       (rst),
      .keycode_i (sc.keycode),
      .code_i    (KEY_ABORT),
      .strobe_o  (abort_ev)
   );

   assign fe = sc.vblnk & ~vblnk_q;

   always_comb begin
      target_d = target_q;
      case (target_q)
         START: begin
            if (start_ev) target_d = GAME;
         end
         GAME: begin
            // Win checks wait for the committed GAME screen so stale scores are ignored.
            if (screen_q == GAME && sc.p1_score >= WIN_SCORE)      target_d = PLAYER_1;
            else if (screen_q == GAME && sc.p2_score >= WIN_SCORE) target_d = PLAYER_2;
            else if (abort_ev)                                     target_d = START;
         end
         PLAYER_1, PLAYER_2: begin
            if (start_ev || (fe && fcnt_q == CNT_LAST)) target_d = START;
         end
         default: target_d = START;
      endcase
   end

   always_comb begin
      commit     = fe && (target_d != screen_q);
      screen_d   = commit ? target_d : screen_q;
      game_rst_d = commit && (target_d == GAME);
      fcnt_d     = fcnt_q;
      if (commit) begin
         fcnt_d = '0;
      end else if (fe && (screen_q == PLAYER_1 || screen_q == PLAYER_2) && fcnt_q != CNT_LAST) begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q    <= 1'b0;
         target_q   <= START;
         screen_q   <= START;
         fcnt_q     <= '0;
         game_rst_q <= 1'b0;
      end else begin
         vblnk_q    <= sc.vblnk;
         target_q   <= target_d;
         screen_q   <= screen_d;
         fcnt_q     <= fcnt_d;
         game_rst_q <= game_rst_d;
      end
   end

   assign sc.screen   = screen_q;
   assign sc.game_rst = game_rst_q;
   assign sc.pending  = (target_q != screen_q);

endmodule

// File: tb/tb_screen_controller.sv
// tb/tb_screen_controller.sv - directed scoreboard bench for screen_controller
module tb_screen_controller;
   import vga_pkg::*;

   typedef struct {
      string      tag;
      logic [8:0] val;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   rst_pulses;
   exp_t sb[$];

   screen_controller_if bus ();

   screen_controller dut (
      .clk (clk),
      .rst (rst),
      .sc  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.game_rst === 1'b1) rst_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      bus.vblnk = 1'b1;
      step(1);
      bus.vblnk = 1'b0;
      step(1);
   endtask

   task automatic sb_push(input string tag, input logic [8:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic check(input logic [8:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty obs=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic push_state(input string tag, input screen_e s, input logic p, input logic g);
      sb_push({tag, "_screen"}, 9'(s));
      sb_push({tag, "_pending"}, {8'd0, p});
      sb_push({tag, "_game_rst"}, {8'd0, g});
   endtask

   task automatic check_state();
      check(9'(bus.screen));
      check({8'd0, bus.pending});
      check({8'd0, bus.game_rst});
   endtask

   initial begin
      int base;
      checks     = 0;
      errors     = 0;
      rst_pulses = 0;
      rst          = 1'b1;
      bus.vblnk    = 1'b0;
      bus.keycode  = 16'h0000;
      bus.p1_score = 5'd0;
      bus.p2_score = 5'd0;
      step(2);
      push_state("reset", START, 1'b0, 1'b0);
      check_state();
      rst = 1'b0;
      step(1);

      // Start request waits for the frame edge.
      bus.keycode = 16'h005A;
      push_state("req_wait", START, 1'b1, 1'b0);
      step(3);
      check_state();
      bus.vblnk = 1'b1;
      push_state("commit_game", GAME, 1'b0, 1'b1);
      step(1);
      check_state();
      bus.vblnk = 1'b0;
      push_state("after_commit", GAME, 1'b0, 1'b0);
      step(1);
      check_state();

      // Held key over three frames, then a break code.
      base = rst_pulses;
      frame(); frame(); frame();
      bus.keycode = 16'hF05A;
      frame(); frame();
      push_state("held_key", GAME, 1'b0, 1'b0);
      check_state();
      sb_push("held_no_rst", 9'd0);
      check(9'(rst_pulses - base));

      // Below-threshold score, then simultaneous wins.
      bus.p2_score = 5'd9;
      step(2);
      frame();
      push_state("p2_nine", GAME, 1'b0, 1'b0);
      check_state();
      bus.p1_score = 5'd10;
      bus.p2_score = 5'd10;
      push_state("tie_wait", GAME, 1'b1, 1'b0);
      step(1);
      check_state();
      bus.vblnk = 1'b1;
      push_state("tie_p1", PLAYER_1, 1'b0, 1'b0);
      step(1);
      check_state();
      bus.vblnk    = 1'b0;
      bus.p1_score = 5'd0;
      bus.p2_score = 5'd0;
      step(1);

      // Enter leaves the win screen.
      bus.keycode = 16'h005A;
      push_state("leave_wait", PLAYER_1, 1'b1, 1'b0);
      step(1);
      check_state();
      frame();
      push_state("leave_p1", START, 1'b0, 1'b0);
      check_state();

      // Player 2 win screen times out after 300 frame edges.
      bus.keycode = 16'h0000;
      step(1);
      bus.keycode = 16'h005A;
      step(1);
      frame();
      bus.p2_score = 5'd10;
      step(1);
      bus.vblnk = 1'b1;
      push_state("enter_p2", PLAYER_2, 1'b0, 1'b0);
      step(1);
      check_state();
      bus.vblnk    = 1'b0;
      bus.p2_score = 5'd0;
      step(1);
      for (int i = 0; i < 299; i++) frame();
      push_state("p2_299", PLAYER_2, 1'b0, 1'b0);
      check_state();
      bus.vblnk = 1'b1;
      push_state("p2_300", START, 1'b0, 1'b0);
      step(1);
      check_state();
      bus.vblnk = 1'b0;
      step(1);

      // Win beats abort in the same cycle.
      bus.keycode = 16'h0000;
      step(1);
      bus.keycode = 16'h005A;
      step(1);
      frame();
      push_state("game_again", GAME, 1'b0, 1'b0);
      check_state();
      bus.keycode  = 16'h0076;
      bus.p1_score = 5'd10;
      step(1);
      frame();
      push_state("win_over_abort", PLAYER_1, 1'b0, 1'b0);
      check_state();
      bus.p1_score = 5'd0;
      bus.keycode  = 16'h005A;
      step(1);
      frame();
      push_state("back_start", START, 1'b0, 1'b0);
      check_state();

      // Reset during the wait discards the request.
      bus.keycode = 16'h0000;
      step(1);
      bus.keycode = 16'h005A;
      push_state("req_again", START, 1'b1, 1'b0);
      step(1);
      check_state();
      base        = rst_pulses;
      rst         = 1'b1;
      bus.keycode = 16'h0000;
      step(1);
      rst = 1'b0;
      push_state("mid_reset", START, 1'b0, 1'b0);
      check_state();
      bus.vblnk = 1'b1;
      push_state("after_reset_edge", START, 1'b0, 1'b0);
      step(1);
      check_state();
      bus.vblnk = 1'b0;
      step(2);
      sb_push("reset_no_rst", 9'd0);
      check(9'(rst_pulses - base));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
